trace_trigger_ctrl: RTL

TRACE_TRIGGER_CTRL -- requirements
Module: trace_trigger_ctrl

---
 rtl/trace_trigger_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/trace_trigger_ctrl.sv
// NoC trace trigger controller: fills a ring buffer with pre-trigger history, captures
// the trigger flit plus a programmable number of post-trigger flits, then parks in DONE.
module trace_trigger_ctrl #(
  parameter int Fpay = 32,
  parameter int AW   = 9,
  parameter int CW   = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Fpay-1:0] flit_in,
  input  logic            flit_valid,
  input  logic            arm,
  input  logic            stop,
  input  logic [Fpay-1:0] match_val,
  input  logic [Fpay-1:0] match_mask,
  input  logic [CW-1:0]   post_len,
  output logic [Fpay-1:0] trace,
  output logic            trigger,
  output logic [AW-1:0]   trig_addr,
  output logic [1:0]      state,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CW-1:0] PCNT_ONE = CW'(1);
  localparam logic [AW-1:0] WCNT_ONE = AW'(1);

  state_e          state_q, state_d;
  logic [Fpay-1:0] trace_q;
  logic            trigger_q, trigger_d;
  logic [AW-1:0]   trig_addr_q;
  logic [AW-1:0]   wcnt_q;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic            hit;
  logic            trig_load;

  assign hit = flit_valid & ((flit_in & match_mask) == (match_val & match_mask));

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    trigger_d = 1'b0;
    trig_load = 1'b0;
    case (state_q)
      IDLE: if (arm) state_d = PRE;
      PRE: begin
        if (flit_valid) begin
          trigger_d = 1'b1;
          if (hit) begin
            trig_load = 1'b1;
            pcnt_d    = post_len;
            state_d   = (post_len == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (flit_valid) begin
          trigger_d = 1'b1;
          pcnt_d    = pcnt_q - PCNT_ONE;
          if (pcnt_q == PCNT_ONE) state_d = DONE;
        end
      end
      DONE: if (arm) state_d = PRE;
      default: state_d = IDLE;
    endcase
    // stop wins over arm and hit, and also kills the write in this cycle
    if (stop) begin
      state_d   = IDLE;
      pcnt_d    = pcnt_q;
      trigger_d = 1'b0;
      trig_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      trace_q     <= '0;
      trigger_q   <= 1'b0;
      trig_addr_q <= '0;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      trigger_q <= trigger_d;
      if (trigger_d) begin
        trace_q <= flit_in;
        wcnt_q  <= wcnt_q + WCNT_ONE;
      end
      // write pointer value before increment is the buffer slot the trigger flit lands in
      if (trig_load) trig_addr_q <= wcnt_q;
    end
  end

  assign trace     = trace_q;
  assign trigger   = trigger_q;
  assign trig_addr = trig_addr_q;
  assign state     = state_q;
  assign done      = (state_q == DONE);

endmodule
